// File: rtl/uart_word_tx_if.sv
// Request/status bundle between the interconnect UART write path and uart_word_tx.
// master = interconnect side (drives the request), slave = transmitter side.
interface uart_word_tx_if #(
  parameter int CNT_W = 16
);
  logic             i_Tx_DV;
  logic [31:0]      i_tx_word;
  logic [3:0]       i_wstrb;
  logic             o_Tx_Active;
  logic             o_Tx_Done;
  logic             o_Tx_Serial;
  logic [CNT_W-1:0] o_bytes_sent;

  modport master (
    output i_Tx_DV, i_tx_word, i_wstrb,
    input  o_Tx_Active, o_Tx_Done, o_Tx_Serial, o_bytes_sent
  );

  modport slave (
    input  i_Tx_DV, i_tx_word, i_wstrb,
    output o_Tx_Active, o_Tx_Done, o_Tx_Serial, o_bytes_sent
  );
endinterface

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: each strobed byte lane goes out as one frame, lowest lane first.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit); default build is 8N1.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_word_tx_if.slave tx
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [TW-1:0]    bit_timer;
  logic [2:0]       bit_idx;
  logic [1:0]       lane;
  logic [31:0]      shadow_word;
  logic [3:0]       shadow_strb;
  logic [3:0]       strb_left;
  logic [7:0]       cur_byte;
  logic [CNT_W-1:0] bytes_sent;
  logic             bit_end;

  logic             serial_d;
  logic             active_d;
  logic             done_d;
  logic             serial_q;
  logic             active_q;
  logic             done_q;

  function automatic logic [1:0] low_lane(input logic [3:0] s);
    logic [1:0] l;
    if (s[0])      l = 2'd0;
    else if (s[1]) l = 2'd1;
    else if (s[2]) l = 2'd2;
    else           l = 2'd3;
    return l;
  endfunction

  assign bit_end   = (bit_timer == TMAX);
  assign cur_byte  = shadow_word[{lane, 3'b000} +: 8];
  assign strb_left = shadow_strb & ~(4'b0001 << lane);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    serial_d   = 1'b1;
    active_d   = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (tx.i_Tx_DV) next_state = (tx.i_wstrb != 4'd0) ? START : DONE;
      end
      START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        serial_d = cur_byte[bit_idx];
        active_d = 1'b1;
`ifdef UART_TX_PARITY_EN
        if (bit_end && bit_idx == 3'd7) next_state = PARITY;
`else
        if (bit_end && bit_idx == 3'd7) next_state = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = ^cur_byte;
        active_d = 1'b1;
        if (bit_end) next_state = STOP;
      end
`endif
      STOP: begin
        active_d = 1'b1;
        // Next lane starts straight out of STOP so frames are back-to-back.
        if (bit_end) next_state = (strb_left != 4'd0) ? START : DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_timer   <= '0;
      bit_idx     <= '0;
      lane        <= '0;
      shadow_word <= '0;
      shadow_strb <= '0;
      bytes_sent  <= '0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;

      if (state == IDLE || state == DONE || bit_end) bit_timer <= '0;
      else                                           bit_timer <= bit_timer + 1'b1;

      if (state != DATA)  bit_idx <= '0;
      else if (bit_end)   bit_idx <= bit_idx + 3'd1;

      if (state == IDLE && tx.i_Tx_DV) begin
        shadow_word <= tx.i_tx_word;
        shadow_strb <= tx.i_wstrb;
        lane        <= low_lane(tx.i_wstrb);
      end

      if (state == STOP && bit_end) begin
        shadow_strb <= strb_left;
        lane        <= low_lane(strb_left);
        if (bytes_sent != {CNT_W{1'b1}}) bytes_sent <= bytes_sent + 1'b1;
      end
    end
  end

  assign tx.o_Tx_Serial  = serial_q;
  assign tx.o_Tx_Active  = active_q;
  assign tx.o_Tx_Done    = done_q;
  assign tx.o_bytes_sent = bytes_sent;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at CLKS_PER_BIT=4; follows UART_TX_PARITY_EN like the RTL.
module tb_uart_word_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic s_log [0:399];
  logic a_log [0:399];
  logic d_log [0:399];
  int   n_log;

  always #5 clk = ~clk;

  uart_word_tx_if #(.CNT_W(16)) bus ();

  uart_word_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [31:0] w, input logic [3:0] s, input int idx);
    int         f   = idx / (FB * CPB);
    int         b   = (idx / CPB) % FB;
    int         cnt = 0;
    logic [7:0] byt = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) begin
        if (cnt == f) byt = w[8*k +: 8];
        cnt++;
      end
    end
    if (b == 0) return 1'b0;
    if (b <= 8) return byt[b-1];
    if (FB == 11 && b == 9) return ^byt;
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.i_Tx_DV = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; logs outputs each cycle after the accept edge.
  task automatic send(input logic [31:0] w, input logic [3:0] s, input bit hold);
    bit saw_done;
    bus.i_Tx_DV   = 1'b1;
    bus.i_tx_word = w;
    bus.i_wstrb   = s;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.i_tx_word = 32'hFFFF_FFFF;
      bus.i_wstrb   = 4'hF;
    end else begin
      bus.i_Tx_DV = 1'b0;
    end
    n_log    = 0;
    saw_done = 1'b0;
    while (!saw_done && n_log < 300) begin
      @(posedge clk);
      #1;
      s_log[n_log] = bus.o_Tx_Serial;
      a_log[n_log] = bus.o_Tx_Active;
      d_log[n_log] = bus.o_Tx_Done;
      if (bus.o_Tx_Done) saw_done = 1'b1;
      n_log++;
    end
    bus.i_Tx_DV = 1'b0;
  endtask

  task automatic check_request(input string tag, input logic [31:0] w, input logic [3:0] s,
                               input int nbytes);
    int act   = 0;
    int dones = 0;
    int len   = nbytes * FB * CPB;
    for (int i = 0; i < n_log; i++) begin
      act   += int'(a_log[i]);
      dones += int'(d_log[i]);
    end
    check({tag, " active_cycles"}, act, len);
    check({tag, " done_count"}, dones, 1);
    check({tag, " done_index"}, n_log - 1, len);
    if (nbytes > 0) check({tag, " active_first"}, a_log[0], 1'b1);
    for (int i = 0; i < len && i < n_log; i++)
      check($sformatf("%s serial[%0d]", tag, i), s_log[i], exp_bit(w, s, i));
    if (n_log > 0) check({tag, " serial_at_done"}, s_log[n_log-1], 1'b1);
  endtask

  initial begin
    bus.i_Tx_DV   = 1'b0;
    bus.i_tx_word = '0;
    bus.i_wstrb   = '0;

    // T1 reset
    do_reset();
    check("t1 serial", bus.o_Tx_Serial, 1'b1);
    check("t1 active", bus.o_Tx_Active, 1'b0);
    check("t1 done", bus.o_Tx_Done, 1'b0);
    check("t1 bytes", bus.o_bytes_sent, 16'd0);
    @(posedge clk); #1;
    check("t1 idle_serial", bus.o_Tx_Serial, 1'b1);

    // T2 single byte 0x55 on lane 0
    send(32'h0000_0055, 4'b0001, 1'b0);
    check_request("t2", 32'h0000_0055, 4'b0001, 1);
    check("t2 bytes", bus.o_bytes_sent, 16'd1);

    // T3 non-contiguous lanes 1 and 3: 0xC3 then 0xA1
    do_reset();
    @(posedge clk); #1;
    send(32'hA1B2_C3D4, 4'b1010, 1'b0);
    check_request("t3", 32'hA1B2_C3D4, 4'b1010, 2);
    check("t3 bytes", bus.o_bytes_sent, 16'd2);

    // T4 zero strobe: immediate Done, line untouched
    @(posedge clk); #1;
    send(32'h1234_5678, 4'b0000, 1'b0);
    check_request("t4", 32'h1234_5678, 4'b0000, 0);
    check("t4 bytes", bus.o_bytes_sent, 16'd2);

    // T5a busy: DV held and inputs changed during the request are ignored
    do_reset();
    @(posedge clk); #1;
    send(32'h0000_0055, 4'b0001, 1'b1);
    check_request("t5a", 32'h0000_0055, 4'b0001, 1);
    check("t5a bytes", bus.o_bytes_sent, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5a idle_active", bus.o_Tx_Active, 1'b0);

    // T5b abort mid-DATA: index 10 is data bit 1 of 0x55, a 0 on the line
    bus.i_Tx_DV   = 1'b1;
    bus.i_tx_word = 32'h0000_0055;
    bus.i_wstrb   = 4'b0001;
    @(posedge clk); #1;
    bus.i_Tx_DV = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("t5b pre_abort_serial", bus.o_Tx_Serial, 1'b0);
    check("t5b pre_abort_active", bus.o_Tx_Active, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5b abort_serial", bus.o_Tx_Serial, 1'b1);
    check("t5b abort_active", bus.o_Tx_Active, 1'b0);
    check("t5b abort_done", bus.o_Tx_Done, 1'b0);
    rst = 1'b0;
    begin
      int done_seen = 0;
      int low_seen  = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        done_seen += int'(bus.o_Tx_Done);
        low_seen  += int'(!bus.o_Tx_Serial);
      end
      check("t5b no_done", done_seen, 0);
      check("t5b line_idle", low_seen, 0);
      check("t5b bytes", bus.o_bytes_sent, 16'd0);
    end

`ifdef UART_TX_PARITY_EN
    // T6 parity: 0x07 has three ones, so the even-parity bit is 1
    @(posedge clk); #1;
    send(32'h0000_0007, 4'b0001, 1'b0);
    check_request("t6", 32'h0000_0007, 4'b0001, 1);
    check("t6 parity_bit", s_log[9*CPB+1], 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
